// File: rtl/b2_pkg.sv
// ---------------------------------------------------------------------------
// b2_pkg: shared constants for the b2 sliding-window block.
//   Defaults for sample width, window length and frame length, plus the FSM
//   state encoding used by b2_slide_window.
// ---------------------------------------------------------------------------
package b2_pkg;

  localparam int unsigned DATA_W_DEF    = 7;
  localparam int unsigned TAPS_DEF      = 8;
  localparam int unsigned FRAME_LEN_DEF = 909;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_FILL  = 2'd1;
  localparam logic [ST_W-1:0] ST_SLIDE = 2'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/b2_tap_shift.sv
// ---------------------------------------------------------------------------
// b2_tap_shift: tap delay line plus registered window lanes.
//   clk, rst_n : clock, async active-low reset (taps and lanes clear to 0)
//   shift_en   : shift din into the newest tap, dropping the oldest
//   load_en    : capture the post-shift tap contents into the lane register
//   din        : incoming sample
//   lanes      : lane i at bits [i*DATA_W +: DATA_W]; lane 0 oldest
// load_en is meant to be used together with shift_en; the lanes always take
// the shifted view so a window appears one cycle after its newest sample.
// ---------------------------------------------------------------------------
module b2_tap_shift #(
  parameter int unsigned DATA_W = 7,
  parameter int unsigned TAPS   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift_en,
  input  logic                     load_en,
  input  logic [DATA_W-1:0]        din,
  output logic [TAPS*DATA_W-1:0]   lanes
);

  logic [TAPS*DATA_W-1:0] taps_q;
  logic [TAPS*DATA_W-1:0] taps_nxt;

  // Newest sample enters the top lane; everything moves one lane toward 0.
  assign taps_nxt = {din, taps_q[TAPS*DATA_W-1:DATA_W]};

  // Tap and lane registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q <= '0;
      lanes  <= '0;
    end else begin
      if (shift_en) taps_q <= taps_nxt;
      if (load_en)  lanes  <= taps_nxt;
    end
  end

endmodule

// File: rtl/b2_slide_window.sv
// ---------------------------------------------------------------------------
// b2_slide_window: stride-1 sliding window over a fixed-length sample frame.
//   clk, rst_n       : clock, async active-low reset
//   start            : begins a frame when idle, ignored otherwise
//   in_valid/in_data : sample stream; in_ready accepts it
//   Slide_data_0..7  : window lanes, lane 0 oldest, lane 7 newest
//   out_valid        : lanes hold a window; consumed when out_ready is high
//   busy             : block is inside a frame
//   frame_done       : one-cycle pulse after the last window is consumed
// in_ready is a combinational function of registered state and out_ready so
// the window path can stream at one sample per cycle.
// ---------------------------------------------------------------------------
module b2_slide_window
  import b2_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned TAPS      = TAPS_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] Slide_data_0,
  output logic [DATA_W-1:0] Slide_data_1,
  output logic [DATA_W-1:0] Slide_data_2,
  output logic [DATA_W-1:0] Slide_data_3,
  output logic [DATA_W-1:0] Slide_data_4,
  output logic [DATA_W-1:0] Slide_data_5,
  output logic [DATA_W-1:0] Slide_data_6,
  output logic [DATA_W-1:0] Slide_data_7,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN);

  logic [ST_W-1:0]        state_q;
  logic [ST_W-1:0]        state_nxt;
  logic [CNT_W-1:0]       cnt_q;
  logic                   accept;
  logic                   xfer;
  logic                   fill_last;
  logic                   frame_last;
  logic                   ov_nxt;
  logic                   fd_nxt;
  logic [TAPS*DATA_W-1:0] lanes;

  // Handshake qualifiers.
  assign in_ready = (state_q == ST_FILL) ||
                    ((state_q == ST_SLIDE) && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // cnt_q holds the 0-based index of the next sample to be accepted.
  assign fill_last  = (cnt_q == CNT_W'(TAPS - 2));
  assign frame_last = (cnt_q == CNT_W'(FRAME_LEN - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    ov_nxt    = out_valid;
    fd_nxt    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ov_nxt = 1'b0;
        if (start) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        if (accept && fill_last) state_nxt = ST_SLIDE;
      end
      ST_SLIDE: begin
        // A new sample always yields a window; a bare transfer empties it.
        if (accept)    ov_nxt = 1'b1;
        else if (xfer) ov_nxt = 1'b0;
        if (accept && frame_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer) begin
          ov_nxt    = 1'b0;
          fd_nxt    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sample counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) cnt_q <= '0;
      else if (accept && !frame_last)    cnt_q <= cnt_q + CNT_W'(1);
      out_valid  <= ov_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= fd_nxt;
    end
  end

  b2_tap_shift #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_tap_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept),
    .load_en  (accept && (state_q == ST_SLIDE)),
    .din      (in_data),
    .lanes    (lanes)
  );

  assign Slide_data_0 = lanes[0*DATA_W +: DATA_W];
  assign Slide_data_1 = lanes[1*DATA_W +: DATA_W];
  assign Slide_data_2 = lanes[2*DATA_W +: DATA_W];
  assign Slide_data_3 = lanes[3*DATA_W +: DATA_W];
  assign Slide_data_4 = lanes[4*DATA_W +: DATA_W];
  assign Slide_data_5 = lanes[5*DATA_W +: DATA_W];
  assign Slide_data_6 = lanes[6*DATA_W +: DATA_W];
  assign Slide_data_7 = lanes[7*DATA_W +: DATA_W];

endmodule

// File: tb/tb_b2_slide_window.sv
// ---------------------------------------------------------------------------
// tb_b2_slide_window: self-checking bench for b2_slide_window.
//   A directed cycle table covers reset, fill, first-window latency, stall
//   and start-ignore behaviour; a frame-level reference model (the list of
//   accepted samples and a window index) checks every cycle of randomized
//   frames, stalls, mid-frame reset and back-to-back frames.
// ---------------------------------------------------------------------------
module tb_b2_slide_window;

  localparam int DW = 7;
  localparam int TP = 8;
  localparam int FL = 909;
  localparam int NW = FL - TP + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] Slide_data_0, Slide_data_1, Slide_data_2, Slide_data_3;
  logic [DW-1:0] Slide_data_4, Slide_data_5, Slide_data_6, Slide_data_7;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          frame_done;

  b2_slide_window #(.DATA_W(DW), .TAPS(TP), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .Slide_data_0 (Slide_data_0),
    .Slide_data_1 (Slide_data_1),
    .Slide_data_2 (Slide_data_2),
    .Slide_data_3 (Slide_data_3),
    .Slide_data_4 (Slide_data_4),
    .Slide_data_5 (Slide_data_5),
    .Slide_data_6 (Slide_data_6),
    .Slide_data_7 (Slide_data_7),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] lane [TP];
  assign lane[0] = Slide_data_0;
  assign lane[1] = Slide_data_1;
  assign lane[2] = Slide_data_2;
  assign lane[3] = Slide_data_3;
  assign lane[4] = Slide_data_4;
  assign lane[5] = Slide_data_5;
  assign lane[6] = Slide_data_6;
  assign lane[7] = Slide_data_7;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit            m_active;
  bit            m_ov;
  bit            m_fd;
  int            acc;
  int            win;
  int            samp [FL];
  int            fd_count = 0;
  bit            prev_stall;
  logic [DW-1:0] prev_lanes [TP];

  always @(negedge clk) begin : mon
    bit was_active, acc_now, xf_now, exp_ir;
    if (!rst_n) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      for (int j = 0; j < TP; j++) chk("rst_lane", int'(lane[j]), 0);
      m_active   = 1'b0;
      m_ov       = 1'b0;
      m_fd       = 1'b0;
      acc        = 0;
      win        = 0;
      prev_stall = 1'b0;
    end else begin
      was_active = m_active;
      chk("busy", int'(busy), int'(m_active));
      chk("out_valid", int'(out_valid), int'(m_ov));
      chk("frame_done", int'(frame_done), int'(m_fd));
      if (frame_done) fd_count++;

      if (!m_active)         exp_ir = 1'b0;
      else if (acc >= FL)    exp_ir = 1'b0;
      else if (acc < TP - 1) exp_ir = 1'b1;
      else                   exp_ir = !m_ov || out_ready;
      chk("in_ready", int'(in_ready), int'(exp_ir));

      if (prev_stall)
        for (int j = 0; j < TP; j++) chk("stall_hold", int'(lane[j]), int'(prev_lanes[j]));

      acc_now = in_valid && in_ready;
      xf_now  = out_valid && out_ready;

      // Window k must be samples k..k+7 of the accepted stream.
      if (xf_now && m_active) begin
        chk("window_avail", int'(win + TP <= acc), 1);
        if (win + TP <= acc)
          for (int j = 0; j < TP; j++) chk("window_lane", int'(lane[j]), samp[win + j]);
        win++;
      end

      m_fd = 1'b0;
      if (xf_now && m_active && win == NW) begin
        m_active = 1'b0;
        m_fd     = 1'b1;
      end

      if (acc_now && m_active && acc < FL) begin
        samp[acc] = int'(in_data);
        acc++;
      end

      if (acc_now && acc >= TP) m_ov = 1'b1;
      else if (xf_now)          m_ov = 1'b0;

      if (start && !was_active) begin
        m_active = 1'b1;
        acc      = 0;
        win      = 0;
      end

      prev_stall = out_valid && !out_ready;
      prev_lanes = lane;
    end
  end

  // ---------------- stimulus helpers ----------------
  int stall_left = 0;

  function automatic logic pick_ready(input int rmode);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return logic'($urandom_range(1));
    if (stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    if ($urandom_range(39) == 0) begin
      stall_left = 4;
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic run_frame(input int base, input int vprob, input int rmode,
                           input bit noise, input int stop_at);
    int idx, budget, fd0;
    fd0 = fd_count;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; budget = 0;
    while (idx < stop_at && budget < 20000) begin
      in_valid  = ($urandom_range(99) < vprob);
      in_data   = DW'(base + idx);
      out_ready = pick_ready(rmode);
      start     = noise && ($urandom_range(15) == 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk("sample_budget", int'(budget < 20000), 1);
    if (stop_at < FL) return;
    while (fd_count == fd0 && budget < 20000) begin
      out_ready = pick_ready(rmode);
      start     = noise && !out_ready && ($urandom_range(3) == 0);
      @(negedge clk);
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0; out_ready = 1'b1;
    chk("drain_budget", int'(budget < 20000), 1);
    chk("frame_done_count", fd_count - fd0, 1);
    chk("windows_per_frame", win, NW);
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    bit st; bit iv; int d; bit ordy;
    bit e_ir; bit e_ov; bit e_busy; int e_l0; int e_l7;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : main
    int fd0;
    tbl[0]  = '{1, 0,  0, 1, 0, 0, 0,  0,  0};
    tbl[1]  = '{0, 1, 10, 1, 1, 0, 1,  0,  0};
    tbl[2]  = '{0, 1, 11, 1, 1, 0, 1,  0,  0};
    tbl[3]  = '{0, 1, 12, 1, 1, 0, 1,  0,  0};
    tbl[4]  = '{0, 1, 13, 1, 1, 0, 1,  0,  0};
    tbl[5]  = '{0, 1, 14, 1, 1, 0, 1,  0,  0};
    tbl[6]  = '{0, 1, 15, 1, 1, 0, 1,  0,  0};
    tbl[7]  = '{0, 1, 16, 1, 1, 0, 1,  0,  0};
    tbl[8]  = '{0, 1, 17, 0, 1, 0, 1,  0,  0};
    tbl[9]  = '{0, 1, 18, 0, 0, 1, 1, 10, 17};
    tbl[10] = '{0, 0,  0, 1, 1, 1, 1, 10, 17};
    tbl[11] = '{0, 0,  0, 1, 1, 0, 1, 10, 17};
    tbl[12] = '{0, 1, 18, 1, 1, 0, 1, 10, 17};
    tbl[13] = '{0, 0,  0, 0, 0, 1, 1, 11, 18};
    tbl[14] = '{1, 0,  0, 0, 0, 1, 1, 11, 18};
    tbl[15] = '{0, 0,  0, 0, 0, 1, 1, 11, 18};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv;
      in_data = DW'(tbl[i].d); out_ready = tbl[i].ordy;
      @(negedge clk);
      chk("tbl_in_ready", int'(in_ready), int'(tbl[i].e_ir));
      chk("tbl_out_valid", int'(out_valid), int'(tbl[i].e_ov));
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
      chk("tbl_lane0", int'(Slide_data_0), tbl[i].e_l0);
      chk("tbl_lane7", int'(Slide_data_7), tbl[i].e_l7);
      @(posedge clk); #1;
    end

    // Reset in the middle of the table frame.
    fd0 = fd_count;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", fd_count - fd0, 0);

    // Full-rate frame 0..908.
    run_frame(0, 100, 0, 1'b0, FL);
    // Random input gaps.
    run_frame(0, 50, 0, 1'b0, FL);
    // Five-cycle output stalls.
    run_frame(0, 100, 2, 1'b0, FL);

    // Abort after 300 samples, then a fresh frame 100..1008.
    fd0 = fd_count;
    run_frame(0, 100, 0, 1'b0, 300);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("no_done_aborted_frame", fd_count - fd0, 0);
    run_frame(100, 100, 0, 1'b0, FL);

    // Back-to-back frames with spurious start pulses.
    run_frame(5, 70, 1, 1'b1, FL);
    run_frame(37, 70, 1, 1'b1, FL);

    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b2_slide_window.md
B2_SLIDE_WINDOW -- requirements
Module: b2_slide_window

Interface
REQ-001 SHALL have parameter DATA_W, default 7, meaning sample width in bits.
REQ-002 SHALL have parameter TAPS, default 8, meaning window length (fixed at 8 output lanes).
REQ-003 SHALL have parameter FRAME_LEN, default 909, meaning input samples per frame (FRAME_LEN-TAPS+1 = 902 windows).
REQ-004 clk  input  1  clock, all logic on rising edge; single clock domain.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins a frame when in IDLE, ignored otherwise.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_data  input  DATA_W  unsigned input sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 Slide_data_0 .. Slide_data_7  output  DATA_W each  window lanes; lane 0 oldest, lane 7 newest sample.
REQ-011 out_valid  output  1  Slide_data_0..7 hold a valid window.
REQ-012 out_ready  input  1  downstream consumes window this cycle.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  single-cycle pulse when the last window of a frame is consumed.

Function
REQ-015 Sample accepted iff in_valid && in_ready; window transferred iff out_valid && out_ready.
REQ-016 FSM states SHALL be IDLE, FILL, SLIDE, DRAIN.
REQ-017 IDLE -> FILL on start; sample counter cleared to 0, tap shift register contents unchanged (overwritten by fill).
REQ-018 FILL: in_ready=1; each accepted sample shifts into 8-deep tap register (newest at tap 7); after TAPS-1 = 7 accepted samples -> SLIDE.
REQ-019 SLIDE: in_ready = !out_valid || out_ready; each accepted sample shifts in and, next cycle, Slide_data_0..7 = taps 0..7 with out_valid=1 (latency 1 cycle from acceptance of 8th+ sample).
REQ-020 SLIDE: out_valid && !out_ready SHALL hold Slide_data_0..7 and out_valid stable and deassert in_ready (no window lost or overwritten).
REQ-021 SLIDE: window transferred with no new sample accepted same cycle SHALL clear out_valid next cycle.
REQ-022 Sample counter counts accepted samples in FILL and SLIDE; acceptance of sample FRAME_LEN-1 (0-based) -> DRAIN.
REQ-023 DRAIN: in_ready=0; on transfer of final window, out_valid clears, frame_done pulses for exactly one cycle, state -> IDLE.
REQ-024 Exactly FRAME_LEN-TAPS+1 = 902 windows SHALL be produced per frame, consecutive windows offset by one sample (stride 1).
REQ-025 IDLE: in_ready=0, out_valid=0; start asserted in any non-IDLE state SHALL be ignored.
REQ-026 Counter width SHALL be $clog2(FRAME_LEN) bits; no wrap within a frame.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, counter 0, taps 0, Slide_data_0..7 = 0, out_valid=0, in_ready=0, busy=0, frame_done=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no frame_done; first start after reset release begins a fresh frame.

Structure
REQ-029 FSM state encoding and DATA_W/TAPS/FRAME_LEN defaults SHALL reside in shared package b2_pkg.
REQ-030 Tap register and lane output register SHALL be one sub-module b2_tap_shift (parameterised DATA_W, TAPS, with shift-enable and load-output-enable).

Verification
REQ-031 start, in_data = 0,1,2,...,908 with in_valid=1, out_ready=1 -> 902 windows, window k lanes = k..k+7, first out_valid 1 cycle after 8th sample, one frame_done after window 901.
REQ-032 out_ready low for 5 cycles while out_valid=1 -> lanes and out_valid stable, in_ready=0 throughout, no sample dropped (window sequence still k..k+7).
REQ-033 in_valid toggled randomly (50%) -> identical 902-window sequence as REQ-031, out_valid only after accepted samples.
REQ-034 rst_n low after 300 samples, then start and new frame 100..1008 -> outputs zero during reset, no frame_done for aborted frame, windows k = 100+k..107+k.
REQ-035 start pulsed during SLIDE and DRAIN -> ignored, counter and window sequence unaffected; two back-to-back frames each give 902 windows and one frame_done.
